// File: rtl/color_sensor_emulator.sv
// Colour-sensor emulator: produces a 50% duty square wave whose half-period is
// a programmable per-photodiode register scaled by the selected output scaling.
// Optional macro COLOR_EMU_JITTER_EN adds 0..3 cycles of LFSR jitter per half-period.
module color_sensor_emulator #(
  parameter int unsigned HP_W      = 16,
  parameter int unsigned DEF_RED   = 1000,
  parameter int unsigned DEF_BLUE  = 1100,
  parameter int unsigned DEF_GREEN = 1200,
  parameter int unsigned DEF_CLEAR = 400
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      scale,
  input  logic [1:0]      filter,
  input  logic            enf,
  input  logic            wr_en,
  input  logic [1:0]      wr_sel,
  input  logic [HP_W-1:0] wr_data,
  output logic            sensor_freq,
  output logic            freq_valid
);

  // N = hp * 50 fits in HP_W+6 bits; one extra bit leaves room for jitter
  localparam int unsigned NW = HP_W + 6;
  localparam int unsigned CW = NW + 1;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    RUN_LO = 2'd1,
    RUN_HI = 2'd2
  } state_t;

  // Register index follows the filter encoding: red, blue, clear, green
  logic [HP_W-1:0] hp [4];
  state_t          state;
  state_t          entry_st;
  logic [4:0]      ctrl;
  logic [4:0]      ctrl_q;
  logic [HP_W-1:0] hp_sel;
  logic [5:0]      mult;
  logic [NW-1:0]   n_sel;
  logic [CW-1:0]   len_new;
  logic [CW-1:0]   n_lat;
  logic [CW-1:0]   count;
  logic            zero_n;
  logic            hard_off;
  logic            off_in;
  logic            changed;
  logic            terminal;
  logic            go_off;
  logic            go_entry;

`ifdef COLOR_EMU_JITTER_EN
  logic [15:0] lfsr;

  // Jitter source, stepped once per half-period entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (go_entry) begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end
`endif

  // Half-period length the next state entry would latch
  always_comb begin
    hp_sel = hp[filter];
    case (scale)
      2'b11:   mult = 6'd1;
      2'b10:   mult = 6'd5;
      2'b01:   mult = 6'd50;
      default: mult = 6'd0;
    endcase
    n_sel = NW'(hp_sel) * NW'(mult);
`ifdef COLOR_EMU_JITTER_EN
    len_new = CW'(n_sel) + CW'(lfsr[1:0]);
`else
    len_new = CW'(n_sel);
`endif
    zero_n   = (hp_sel == '0);
    hard_off = enf || (scale == 2'b00);
    off_in   = hard_off || zero_n;
    ctrl     = {enf, scale, filter};
    changed  = (ctrl != ctrl_q);
    terminal = (count == n_lat - CW'(1));
  end

  // Transition decision: shut down, (re)enter a run state, or keep counting
  always_comb begin
    go_off   = 1'b0;
    go_entry = 1'b0;
    entry_st = RUN_LO;
    if (state == OFF) begin
      go_entry = !off_in;
    end else if (hard_off) begin
      go_off = 1'b1;
    end else if (changed || terminal) begin
      if (zero_n) begin
        go_off = 1'b1;
      end else begin
        go_entry = 1'b1;
        if (!changed && state == RUN_LO) begin
          entry_st = RUN_HI;
        end
      end
    end
  end

  // Half-period registers; a write only affects the next latch of N
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp[0] <= HP_W'(DEF_RED);
      hp[1] <= HP_W'(DEF_BLUE);
      hp[2] <= HP_W'(DEF_CLEAR);
      hp[3] <= HP_W'(DEF_GREEN);
    end else if (wr_en) begin
      hp[wr_sel] <= wr_data;
    end
  end

  // Waveform FSM with half-period counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= OFF;
      count       <= '0;
      n_lat       <= '0;
      ctrl_q      <= '0;
      sensor_freq <= 1'b0;
      freq_valid  <= 1'b0;
    end else begin
      ctrl_q <= ctrl;
      if (go_off) begin
        state       <= OFF;
        count       <= '0;
        sensor_freq <= 1'b0;
        freq_valid  <= 1'b0;
      end else if (go_entry) begin
        state       <= entry_st;
        count       <= '0;
        n_lat       <= len_new;
        sensor_freq <= (entry_st == RUN_HI);
        freq_valid  <= 1'b1;
      end else if (state != OFF) begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: doc/color_sensor_emulator.md
COLOR_SENSOR_EMULATOR -- requirements
Module: color_sensor_emulator

Interface
REQ-001 SHALL have parameter HP_W, default 16, meaning half-period register width in clk cycles.
REQ-002 SHALL have parameter DEF_RED, default 1000, meaning red half-period reset value.
REQ-003 SHALL have parameters DEF_BLUE, default 1100, DEF_GREEN, default 1200, DEF_CLEAR, default 400, meaning blue, green and clear half-period reset values.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 scale  in  2  frequency scaling select: 00 power-down, 01 2%, 10 20%, 11 100%.
REQ-007 filter  in  2  photodiode select: 00 red, 01 blue, 10 clear, 11 green.
REQ-008 enf  in  1  active-low output enable; 1 = output disabled.
REQ-009 wr_en  in  1  half-period register write strobe, one cycle.
REQ-010 wr_sel  in  2  target register, same encoding as filter.
REQ-011 wr_data  in  HP_W  half-period value written.
REQ-012 sensor_freq  out  1  emulated sensor square wave, consumed by the colour-sensor reader.
REQ-013 freq_valid  out  1  high while sensor_freq is actively toggling.

Function
REQ-014 SHALL hold four HP_W-bit half-period registers (red, blue, green, clear), written on wr_en at wr_sel with wr_data.
REQ-015 SHALL compute N = hp[filter] * M, M = 1 (scale 11), 5 (scale 10), 50 (scale 01); N width HP_W+6 bits, no truncation.
REQ-016 SHALL implement states OFF, RUN_LO, RUN_HI; sensor_freq = 1 only in RUN_HI.
REQ-017 OFF SHALL be entered next cycle when enf=1, scale=00, or selected hp=0; sensor_freq=0, counter held at 0, freq_valid=0.
REQ-018 RUN_LO/RUN_HI SHALL each last exactly N cycles using the N latched at state entry, then switch to the other; period = 2N cycles, 50% duty.
REQ-019 A change of {enf, scale, filter} versus previous-cycle registered copy SHALL restart: next cycle state RUN_LO (or OFF per REQ-017), counter 0, N re-latched.
REQ-020 OFF SHALL exit to RUN_LO with counter 0 the cycle after all OFF conditions clear.
REQ-021 A write to the active channel SHALL take effect at the next state entry only; the current half-period completes with the old N.
REQ-022 Write and restart in the same cycle: restart SHALL latch the pre-write value; new value used from the following toggle.
REQ-023 freq_valid SHALL be 1 exactly when state is RUN_LO or RUN_HI.
REQ-024 Counter SHALL never wrap: terminal compare is count == N-1, counter cleared on every state change.

Reset
REQ-025 On rst_n=0, immediately: state OFF, sensor_freq=0, freq_valid=0, counter 0, registers = DEF_RED/DEF_BLUE/DEF_GREEN/DEF_CLEAR, registered input copy = current-reset value 0.
REQ-026 Reset asserted mid-period SHALL abort the waveform; after release, first RUN_LO entry follows REQ-019/REQ-020 rules.

Configuration
REQ-027 Macro COLOR_EMU_JITTER_EN defined: 16-bit LFSR x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset, advances once per RUN_LO/RUN_HI entry; each half-period lasts N + lfsr[1:0] cycles.
REQ-028 Macro undefined: no LFSR logic present, half-periods exactly N cycles.

Verification
REQ-029 Reset release, enf=0, scale=11, filter=00, write red=5 before run -> sensor_freq period 10 clk, high 5, freq_valid=1.
REQ-030 Red=5, scale switched 11->10 mid-high -> next cycle sensor_freq=0, then 25 low / 25 high cycles.
REQ-031 enf pulsed 1 for 3 cycles during RUN_HI -> sensor_freq=0 and freq_valid=0 from next cycle; restart with full 5-cycle low phase.
REQ-032 Write blue=0 with filter=01 -> OFF after the next restart or toggle-entry, sensor_freq held 0, freq_valid=0.
REQ-033 Default regs, filter 00->01->11->10 every 20000 cycles at scale=11 -> half-periods 1000, 1100, 1200, 400.
REQ-034 COLOR_EMU_JITTER_EN defined, red=5 -> every half-period in 5..8 cycles, sequence identical across two resets.
